// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX between four byte requesters.
// Optional watchdog on the WAIT state is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int DATA_W = 8,
  parameter int TO_CYC = 200000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [3:0]            i_Req,
  input  logic [4*DATA_W-1:0]   i_Data,
  output logic [3:0]            o_Ack,
  output logic [3:0]            o_Grant,
  output logic                  o_Busy,
  output logic                  o_Tx_fTx,
  output logic [DATA_W-1:0]     o_Tx_Data,
  input  logic                  i_Tx_fReady,
  input  logic                  i_Tx_fDone,
  output logic                  o_Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_win;
  logic [3:0]          r_Ack;
  logic [3:0]          r_Grant;
  logic                r_Busy;
  logic                r_Tx_fTx;
  logic [DATA_W-1:0]   r_Tx_Data;

  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic                w_found;
  logic [3:0]          w_win_onehot;
  logic [3:0]          w_ack_onehot;
  logic [DATA_W-1:0]   w_win_data;

  // Search ptr+1, ptr+2, ptr+3, ptr so the last winner has lowest priority.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && i_Req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_win_onehot = 4'b0001 << w_win;
  assign w_ack_onehot = 4'b0001 << r_win;
  assign w_win_data   = i_Data[w_win*DATA_W +: DATA_W];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_Err;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd3;
      r_win     <= 2'd0;
      r_Ack     <= 4'd0;
      r_Grant   <= 4'd0;
      r_Busy    <= 1'b0;
      r_Tx_fTx  <= 1'b0;
      r_Tx_Data <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_Err     <= 1'b0;
`endif
    end else begin
      r_Ack <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (|i_Req && i_Tx_fReady) begin
            r_win     <= w_win;
            r_Grant   <= w_win_onehot;
            r_Tx_Data <= w_win_data;
            r_Tx_fTx  <= 1'b1;
            r_Busy    <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          r_Tx_fTx <= 1'b0;
          r_state  <= S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          r_cnt    <= '0;
`endif
        end
        S_WAIT: begin
          if (i_Tx_fDone) begin
            r_Ack   <= w_ack_onehot;
            r_ptr   <= r_win;
            r_Grant <= 4'd0;
            r_Busy  <= 1'b0;
            r_state <= S_IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Give up on a stuck transmitter; the owner loses its turn without an ack.
          else if (r_cnt == CW'(TO_CYC - 1)) begin
            r_Err   <= 1'b1;
            r_ptr   <= r_win;
            r_Grant <= 4'd0;
            r_Busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Ack     = r_Ack;
  assign o_Grant   = r_Grant;
  assign o_Busy    = r_Busy;
  assign o_Tx_fTx  = r_Tx_fTx;
  assign o_Tx_Data = r_Tx_Data;
`ifdef UART_ARB_TIMEOUT_EN
  assign o_Err     = r_Err;
`else
  assign o_Err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART_TX stand-in.
module tb_uart_tx_arbiter;
  localparam int TX_LEN = 4;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 200000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        tx_ready_m, hold_ready, tx_ready, tx_done, stall_done;
  logic [3:0]  o_Ack, o_Grant;
  logic        o_Busy, o_Tx_fTx, o_Err;
  logic [7:0]  o_Tx_Data;

  always #5 clk = ~clk;
  assign tx_ready = tx_ready_m & ~hold_ready;

  uart_tx_arbiter #(.DATA_W(8), .TO_CYC(TO)) dut (
    .Clk(clk), .Rst(rst), .i_Req(req), .i_Data(data),
    .o_Ack(o_Ack), .o_Grant(o_Grant), .o_Busy(o_Busy),
    .o_Tx_fTx(o_Tx_fTx), .o_Tx_Data(o_Tx_Data),
    .i_Tx_fReady(tx_ready), .i_Tx_fDone(tx_done), .o_Err(o_Err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] grant;
    logic [7:0] data;
  } txn_t;
  txn_t exp_q[$];
  txn_t mon_t;

  int         ftx_cnt = 0;
  int         ack_cnt = 0;
  int         busy_cnt;
  logic [3:0] cur_ack;
  logic       done_prev, ftx_prev;

  // UART_TX stand-in plus output monitor; everything happens on the falling edge.
  initial begin
    tx_ready_m = 1'b1; tx_done = 1'b0; busy_cnt = 0; ftx_prev = 1'b0; cur_ack = 4'd0;
    forever begin
      @(negedge clk);
      done_prev = tx_done;
      tx_done   = 1'b0;
      if (rst) begin
        tx_ready_m = 1'b1; busy_cnt = 0; ftx_prev = 1'b0; cur_ack = 4'd0;
        continue;
      end
      if (o_Tx_fTx) begin
        ftx_cnt++;
        chk("ftx_width", {31'd0, ftx_prev}, 0);
        chk("ftx_gap", {28'd0, o_Ack}, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ftx", 1, 0);
        end else begin
          mon_t = exp_q.pop_front();
          chk("grant", {28'd0, o_Grant}, {28'd0, mon_t.grant});
          chk("tx_data", {24'd0, o_Tx_Data}, {24'd0, mon_t.data});
          cur_ack = mon_t.grant;
        end
        $display("tx   t=%0t grant=%b data=%h", $time, o_Grant, o_Tx_Data);
        tx_ready_m = 1'b0;
        busy_cnt   = TX_LEN;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          if (!stall_done) tx_done = 1'b1;
          tx_ready_m = 1'b1;
        end
      end
      if (o_Ack != 4'd0) begin
        ack_cnt++;
        chk("ack", {28'd0, o_Ack}, {28'd0, cur_ack});
        chk("ack_latency", {31'd0, done_prev}, 1);
        chk("ack_idle", {27'd0, o_Busy, o_Grant}, 0);
        $display("ack  t=%0t ack=%b", $time, o_Ack);
        cur_ack = 4'd0;
      end
      ftx_prev = o_Tx_fTx;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n, input string tag);
    int tgt = ack_cnt + n;
    int b = 0;
    while (ack_cnt < tgt && b < 3000) begin
      @(negedge clk); #1; b++;
    end
    chk(tag, (ack_cnt >= tgt) ? 32'd1 : 32'd0, 1);
  endtask

  task automatic wait_ftx(input string tag);
    int tgt = ftx_cnt + 1;
    int b = 0;
    while (ftx_cnt < tgt && b < 3000) begin
      @(negedge clk); #1; b++;
    end
    chk(tag, (ftx_cnt >= tgt) ? 32'd1 : 32'd0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, {28'd0, o_Ack}, 0);
    chk({tag, "_grant"}, {28'd0, o_Grant}, 0);
    chk({tag, "_busy"}, {31'd0, o_Busy}, 0);
    chk({tag, "_ftx"}, {31'd0, o_Tx_fTx}, 0);
    chk({tag, "_data"}, {24'd0, o_Tx_Data}, 0);
    chk({tag, "_err"}, {31'd0, o_Err}, 0);
  endtask

  int snap;
  int nwait;

  initial begin
    rst = 1'b1; req = 4'd0; data = 32'd0; hold_ready = 1'b0; stall_done = 1'b0;
    tick(2);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // Lone requester 0, held for two bytes: re-granted right after its ack.
    data[7:0] = 8'h3C;
    req = 4'b0001;
    exp_q.push_back('{4'b0001, 8'h3C});
    exp_q.push_back('{4'b0001, 8'h3C});
    @(negedge clk);
    chk("t1_ftx_n1", {31'd0, o_Tx_fTx}, 1);
    chk("t1_grant", {28'd0, o_Grant}, 4'b0001);
    chk("t1_busy", {31'd0, o_Busy}, 1);
    @(negedge clk);
    chk("t1_ftx_drop", {31'd0, o_Tx_fTx}, 0);
    #1;
    wait_acks(2, "t1_acks");
    req = 4'd0;
    tick(2);

    // All four requesting continuously: fair rotation from requester 0.
    do_reset();
    data = 32'hA3A2A1A0;
    req  = 4'b1111;
    exp_q.push_back('{4'b0001, 8'hA0});
    exp_q.push_back('{4'b0010, 8'hA1});
    exp_q.push_back('{4'b0100, 8'hA2});
    exp_q.push_back('{4'b1000, 8'hA3});
    exp_q.push_back('{4'b0001, 8'hA0});
    wait_acks(5, "t2_acks");
    req = 4'd0;
    tick(2);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Requester 2 drops its request and changes its byte while in flight.
    data[23:16] = 8'hE5;
    req = 4'b0100;
    exp_q.push_back('{4'b0100, 8'hE5});
    wait_ftx("t3_ftx");
    tick(2);
    req = 4'd0;
    data[23:16] = 8'h00;
    tick(1);
    chk("t3_hold_data", {24'd0, o_Tx_Data}, 8'hE5);
    chk("t3_busy", {31'd0, o_Busy}, 1);
    wait_acks(1, "t3_ack");
    tick(2);

    // Transmitter not ready: nothing starts; release grants requester 0.
    do_reset();
    data = 32'h44332211;
    hold_ready = 1'b1;
    req = 4'b1111;
    snap = ftx_cnt;
    tick(10);
    chk("t4_no_ftx", {31'd0, o_Tx_fTx}, 0);
    chk("t4_idle_busy", {31'd0, o_Busy}, 0);
    chk("t4_idle_grant", {28'd0, o_Grant}, 0);
    chk("t4_ftx_count", ftx_cnt, snap);
    exp_q.push_back('{4'b0001, 8'h11});
    hold_ready = 1'b0;
    wait_acks(1, "t4_ack");
    req = 4'd0;
    tick(2);

    // Asynchronous reset in WAIT aborts without ack; priority restarts at 0.
    do_reset();
    data = 32'h00005A00;
    req = 4'b0010;
    exp_q.push_back('{4'b0010, 8'h5A});
    wait_ftx("t5_ftx");
    tick(2);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    snap = ack_cnt;
    tick(2);
    rst = 1'b0;
    chk("t5_no_ack", ack_cnt, snap);
    data = 32'h00005A11;
    req = 4'b0011;
    exp_q.push_back('{4'b0001, 8'h11});
    wait_acks(1, "t5_ack");
    req = 4'd0;
    tick(2);

`ifdef UART_ARB_TIMEOUT_EN
    // Stuck transmitter: watchdog fires after TO WAIT cycles, no ack.
    do_reset();
    data = 32'h000077AB;
    stall_done = 1'b1;
    req = 4'b0001;
    exp_q.push_back('{4'b0001, 8'hAB});
    snap = ack_cnt;
    wait_ftx("t6_ftx");
    nwait = 0;
    while (!o_Err && nwait < 500) begin
      @(negedge clk); #1; nwait++;
    end
    chk("t6_err", {31'd0, o_Err}, 1);
    chk("t6_err_delay", nwait, TO + 1);
    chk("t6_no_ack", ack_cnt, snap);
    chk("t6_idle", {27'd0, o_Busy, o_Grant}, 0);
    cur_ack = 4'd0;
    stall_done = 1'b0;
    req = 4'b0011;
    exp_q.push_back('{4'b0010, 8'h77});
    wait_acks(1, "t6_ack");
    req = 4'd0;
    tick(2);
    chk("t6_err_sticky", {31'd0, o_Err}, 1);
`else
    chk("err_tied_low", {31'd0, o_Err}, 0);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
